lru_matrix_tracker: RTL and testbench
=====================================

Name: lru_matrix_tracker

Overview:
- Parametrised matrix-based LRU tracker for set-associative structures (SM4 key/round-key caches and similar).
- Keeps one WAYS x WAYS age matrix per set.
- Takes two access updates and one invalidate per cycle, all applied in a defined order.
- Returns a registered replacement-victim way for a queried set, honouring a per-query lock mask.

Parameters:
- WAYS, 4, ways per set; legal range 2..16.
- SETS, 1, number of independent sets; legal range 1..64.
- WAY_W, $clog2(WAYS), width of way indices (derived; do not override).
- SET_W, (SETS>1 ? $clog2(SETS) : 1), width of set indices (derived).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- acc1_v_i  in  1  access port 1 valid.
- acc1_set_i  in  SET_W  access port 1 set index.
- acc1_way_i  in  WAY_W  access port 1 way (marked most-recent).
- acc2_v_i  in  1  access port 2 valid.
- acc2_set_i  in  SET_W  access port 2 set index.
- acc2_way_i  in  WAY_W  access port 2 way.
- inv_v_i  in  1  invalidate valid.
- inv_set_i  in  SET_W  invalidate set index.
- inv_way_i  in  WAY_W  invalidate way (forced least-recent).
- query_set_i  in  SET_W  set whose victim is reported.
- lock_mask_i  in  WAYS  bit w=1 excludes way w from victim selection.
- victim_way_o  out  WAY_W  registered victim way.
- victim_valid_o  out  1  registered; 1 = victim_way_o usable.

Behaviour:
- Matrix semantics: M[s][i][j]=1 means way i is more recent than way j (i!=j). Diagonal is always 0 and is never written.
- Access to way a in set s: row a set to 1 (except diagonal), column a cleared.
- Invalidate of way a in set s: row a cleared, column a set to 1 (except diagonal). Way a becomes strictly least-recent.
- Same-cycle ordering: next state = INV(ACC2(ACC1(current))), applied only to the addressed sets.
  - Updates to different sets are independent.
  - Updates to the same set compose in that order.
  - Same way accessed by both ports: identical to a single access.
  - Access and invalidate to the same way/set in one cycle: invalidate wins.
- Ignored requests: any request whose set index >= SETS or way index >= WAYS is dropped, with no state change.
- Victim selection: candidate way w in set q qualifies iff lock_mask_i[w]==0 and (M[q][w] & ~lock_mask_i)==0.
  - Lowest-index qualifying way wins. This covers the post-reset all-zero state, where way 0 wins.
- Victim latency: selection is computed from the next-state matrix of query_set_i, together with lock_mask_i sampled that cycle, and registered.
  - victim_way_o / victim_valid_o at cycle t+1 reflect all updates issued in cycle t.
- Victim-valid rules:
  - All ways locked, or query_set_i >= SETS: victim_valid_o=0, victim_way_o=0.
  - Otherwise victim_valid_o=1.
- Reset (asynchronous, any time including mid-update):
  - All matrices cleared to 0.
  - victim_way_o=0, victim_valid_o=0 immediately.
  - First victim_valid_o=1 appears on the first rising edge after reset_n_i deasserts.
- No handshake or backpressure. Every valid request is consumed in its cycle; the block never stalls.
- No simulation-only display or print code in the RTL.

Test Plan (WAYS=4, SETS=2 unless stated):
- Reset then query set 0, lock=0000 -> next cycle victim_valid_o=1, victim_way_o=0.
- Set 0 accesses 0,1,2,3 on consecutive cycles -> victim 0. Access 0 again -> victim 1. Set 1 query still -> victim 0 (set isolation).
- Set 0 after 0,1,2,3, then same cycle acc1=1, acc2=0 -> victim 2. Then access 2 and 3 -> victim 1, proving port 1 is applied before port 2.
- Set 1 accesses 0,1,2,3, then same cycle acc1=3 and inv=3 -> victim 3. Next cycle invalidate way 1 -> victim 1.
- Set 0 with LRU order 0<1<2<3 and lock=0001 -> victim 1. Lock=1111 -> victim_valid_o=0, victim_way_o=0. Query set 2 (out of range) -> valid 0.
- Assert reset_n_i low mid-sequence, between clock edges -> outputs 0 before the next edge. After release, query any set -> victim 0. Repeat with WAYS=8, SETS=3: accesses to set index 3 are ignored.

Source files
------------

// File: rtl/lru_matrix_tracker_if.sv
// Request/victim bundle for lru_matrix_tracker: two access ports, one invalidate
// port, and the victim query with its registered answer.
interface lru_matrix_tracker_if #(
    parameter int WAYS = 4,
    parameter int SETS = 1
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

    logic             acc1_v_i;
    logic [SET_W-1:0] acc1_set_i;
    logic [WAY_W-1:0] acc1_way_i;
    logic             acc2_v_i;
    logic [SET_W-1:0] acc2_set_i;
    logic [WAY_W-1:0] acc2_way_i;
    logic             inv_v_i;
    logic [SET_W-1:0] inv_set_i;
    logic [WAY_W-1:0] inv_way_i;
    logic [SET_W-1:0] query_set_i;
    logic [WAYS-1:0]  lock_mask_i;
    logic [WAY_W-1:0] victim_way_o;
    logic             victim_valid_o;

    modport master (
        output acc1_v_i, acc1_set_i, acc1_way_i,
        output acc2_v_i, acc2_set_i, acc2_way_i,
        output inv_v_i, inv_set_i, inv_way_i,
        output query_set_i, lock_mask_i,
        input  victim_way_o, victim_valid_o
    );

    modport slave (
        input  acc1_v_i, acc1_set_i, acc1_way_i,
        input  acc2_v_i, acc2_set_i, acc2_way_i,
        input  inv_v_i, inv_set_i, inv_way_i,
        input  query_set_i, lock_mask_i,
        output victim_way_o, victim_valid_o
    );
endinterface

// File: rtl/lru_matrix_tracker.sv
// Matrix-based LRU tracker: one WAYS x WAYS age matrix per set, two accesses and
// one invalidate per cycle, registered victim selection with a per-query lock mask.
module lru_matrix_tracker #(
    parameter int WAYS = 4,
    parameter int SETS = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    lru_matrix_tracker_if.slave bus
);
    localparam int WAY_W = $clog2(WAYS);

    // Row i, column j set means way i is more recent than way j.
    typedef logic [WAYS-1:0][WAYS-1:0] mat_t;

    mat_t             mat_q [SETS];
    mat_t             mat_d [SETS];
    logic [WAY_W-1:0] victim_way_q;
    logic             victim_valid_q;
    logic [WAY_W-1:0] victim_way_d;
    logic             victim_valid_d;
    logic             acc1_ok, acc2_ok, inv_ok;

    function automatic mat_t apply_access(input mat_t m, input logic [WAY_W-1:0] a);
        mat_t r;
        r = m;
        for (int i = 0; i < WAYS; i++) begin
            for (int j = 0; j < WAYS; j++) begin
                if (j == int'(a))      r[i][j] = 1'b0;
                else if (i == int'(a)) r[i][j] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic mat_t apply_invalidate(input mat_t m, input logic [WAY_W-1:0] a);
        mat_t r;
        r = m;
        for (int i = 0; i < WAYS; i++) begin
            for (int j = 0; j < WAYS; j++) begin
                if (i == int'(a))      r[i][j] = 1'b0;
                else if (j == int'(a)) r[i][j] = 1'b1;
            end
        end
        return r;
    endfunction

    // Out-of-range ways are dropped here; out-of-range sets never match any s below.
    assign acc1_ok = bus.acc1_v_i && (int'(bus.acc1_way_i) < WAYS);
    assign acc2_ok = bus.acc2_v_i && (int'(bus.acc2_way_i) < WAYS);
    assign inv_ok  = bus.inv_v_i  && (int'(bus.inv_way_i)  < WAYS);

    always_comb begin
        mat_t m;
        for (int s = 0; s < SETS; s++) begin
            // NOTE: every combinational variable gets a value on every path first, so no latch is inferred.
            m = mat_q[s];
            if (acc1_ok && int'(bus.acc1_set_i) == s) m = apply_access(m, bus.acc1_way_i);
            if (acc2_ok && int'(bus.acc2_set_i) == s) m = apply_access(m, bus.acc2_way_i);
            if (inv_ok  && int'(bus.inv_set_i)  == s) m = apply_invalidate(m, bus.inv_way_i);
            mat_d[s] = m;
        end
    end

    // Victim looks at next-state rows so this cycle's updates are already visible.
    always_comb begin
        mat_t q_mat;
        logic q_ok;
        q_mat          = '0;
        q_ok           = 1'b0;
        victim_way_d   = '0;
        victim_valid_d = 1'b0;
        for (int s = 0; s < SETS; s++) begin
            if (int'(bus.query_set_i) == s) begin
                q_mat = mat_d[s];
                q_ok  = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (q_ok && !victim_valid_d && !bus.lock_mask_i[w] &&
                ((q_mat[w] & ~bus.lock_mask_i) == '0)) begin
                victim_valid_d = 1'b1;
                victim_way_d   = WAY_W'(w);
            end
        end
    end

    // NOTE: the age matrices sit in flops, so the async reset clears them all; a RAM macro could not do this.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < SETS; s++) mat_q[s] <= '0;
            victim_way_q   <= '0;
            victim_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            for (int s = 0; s < SETS; s++) mat_q[s] <= mat_d[s];
            victim_way_q   <= victim_way_d;
            victim_valid_q <= victim_valid_d;
        end
    end

    assign bus.victim_way_o   = victim_way_q;
    assign bus.victim_valid_o = victim_valid_q;
endmodule

// File: tb/tb_lru_matrix_tracker.sv
// Directed bench for lru_matrix_tracker: a vector table on a WAYS=4/SETS=2 instance,
// then hand sequences for mid-cycle reset and a WAYS=8/SETS=3 instance.
module tb_lru_matrix_tracker;
    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    always #5 clk_i = ~clk_i;

    lru_matrix_tracker_if #(.WAYS(4), .SETS(2)) bus_a ();
    lru_matrix_tracker_if #(.WAYS(8), .SETS(3)) bus_b ();

    lru_matrix_tracker #(.WAYS(4), .SETS(2)) dut_a (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus_a.slave)
    );

    lru_matrix_tracker #(.WAYS(8), .SETS(3)) dut_b (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus_b.slave)
    );

    typedef struct {
        logic       a1v; logic a1s; logic [1:0] a1w;
        logic       a2v; logic a2s; logic [1:0] a2w;
        logic       iv;  logic is;  logic [1:0] iw;
        logic       qs;  logic [3:0] lock;
        logic       ev;  logic [1:0] ew;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int a1v, int a1s, int a1w, int a2v, int a2s, int a2w,
                                int iv, int is, int iw, int qs, logic [3:0] lock,
                                int ev, int ew);
        vec_t r;
        r.a1v = a1v[0]; r.a1s = a1s[0]; r.a1w = 2'(a1w);
        r.a2v = a2v[0]; r.a2s = a2s[0]; r.a2w = 2'(a2w);
        r.iv  = iv[0];  r.is  = is[0];  r.iw  = 2'(iw);
        r.qs  = qs[0];  r.lock = lock;
        r.ev  = ev[0];  r.ew  = 2'(ew);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_a();
        bus_a.acc1_v_i = 1'b0; bus_a.acc1_set_i = '0; bus_a.acc1_way_i = '0;
        bus_a.acc2_v_i = 1'b0; bus_a.acc2_set_i = '0; bus_a.acc2_way_i = '0;
        bus_a.inv_v_i  = 1'b0; bus_a.inv_set_i  = '0; bus_a.inv_way_i  = '0;
        bus_a.query_set_i = '0; bus_a.lock_mask_i = '0;
    endtask

    task automatic drive_b(input int a1v, input int a1s, input int a1w,
                           input int a2v, input int a2s, input int a2w,
                           input int iv, input int is, input int iw,
                           input int qs, input logic [7:0] lock);
        bus_b.acc1_v_i = a1v[0]; bus_b.acc1_set_i = 2'(a1s); bus_b.acc1_way_i = 3'(a1w);
        bus_b.acc2_v_i = a2v[0]; bus_b.acc2_set_i = 2'(a2s); bus_b.acc2_way_i = 3'(a2w);
        bus_b.inv_v_i  = iv[0];  bus_b.inv_set_i  = 2'(is);  bus_b.inv_way_i  = 3'(iw);
        bus_b.query_set_i = 2'(qs); bus_b.lock_mask_i = lock;
    endtask

    initial begin
        // a1v a1s a1w  a2v a2s a2w  iv is iw  qs lock  ev ew
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,4'b0000, 1,0)); // 0  first edge after reset
        vq.push_back(mk(1,0,0, 0,0,0, 0,0,0, 0,4'b0000, 1,1)); // 1
        vq.push_back(mk(1,0,1, 0,0,0, 0,0,0, 0,4'b0000, 1,2)); // 2
        vq.push_back(mk(1,0,2, 0,0,0, 0,0,0, 0,4'b0000, 1,3)); // 3
        vq.push_back(mk(1,0,3, 0,0,0, 0,0,0, 0,4'b0000, 1,0)); // 4  order 0<1<2<3
        vq.push_back(mk(1,0,0, 0,0,0, 0,0,0, 0,4'b0000, 1,1)); // 5
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,4'b0000, 1,0)); // 6  set isolation
        vq.push_back(mk(1,0,0, 1,0,1, 0,0,0, 0,4'b0000, 1,2)); // 7
        vq.push_back(mk(1,0,2, 1,0,3, 0,0,0, 0,4'b0000, 1,0)); // 8  order 0<1<2<3
        vq.push_back(mk(1,0,1, 1,0,0, 0,0,0, 0,4'b0000, 1,2)); // 9  port 2 after port 1
        vq.push_back(mk(1,0,2, 0,0,0, 0,0,0, 0,4'b0000, 1,3)); // 10
        vq.push_back(mk(1,0,3, 0,0,0, 0,0,0, 0,4'b0000, 1,1)); // 11 (0 if order reversed)
        vq.push_back(mk(1,1,0, 0,0,0, 0,0,0, 1,4'b0000, 1,1)); // 12
        vq.push_back(mk(1,1,1, 0,0,0, 0,0,0, 1,4'b0000, 1,2)); // 13
        vq.push_back(mk(1,1,2, 0,0,0, 0,0,0, 1,4'b0000, 1,3)); // 14
        vq.push_back(mk(1,1,3, 0,0,0, 0,0,0, 1,4'b0000, 1,0)); // 15
        vq.push_back(mk(1,1,3, 0,0,0, 1,1,3, 1,4'b0000, 1,3)); // 16 invalidate wins
        vq.push_back(mk(0,0,0, 0,0,0, 1,1,1, 1,4'b0000, 1,1)); // 17
        vq.push_back(mk(1,0,1, 1,0,2, 0,0,0, 0,4'b0000, 1,0)); // 18
        vq.push_back(mk(1,0,3, 0,0,0, 0,0,0, 0,4'b0000, 1,0)); // 19 order 0<1<2<3
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,4'b0001, 1,1)); // 20
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,4'b1111, 0,0)); // 21 all locked
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,4'b1011, 1,2)); // 22
        vq.push_back(mk(1,0,0, 1,0,0, 0,0,0, 0,4'b0000, 1,1)); // 23 same way twice
        vq.push_back(mk(1,0,1, 1,1,1, 0,0,0, 1,4'b0000, 1,3)); // 24 different sets
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,4'b0000, 1,2)); // 25
        vq.push_back(mk(1,0,2, 0,0,0, 1,0,0, 0,4'b0000, 1,0)); // 26 inv after access
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,4'b0001, 1,3)); // 27

        idle_a();
        drive_b(0,0,0, 0,0,0, 0,0,0, 0,8'h00);

        #12;
        check("reset_valid_a", int'(bus_a.victim_valid_o), 0);
        check("reset_way_a",   int'(bus_a.victim_way_o),   0);
        check("reset_valid_b", int'(bus_b.victim_valid_o), 0);
        reset_n_i = 1'b1;

        foreach (vq[i]) begin
            bus_a.acc1_v_i = vq[i].a1v; bus_a.acc1_set_i = vq[i].a1s; bus_a.acc1_way_i = vq[i].a1w;
            bus_a.acc2_v_i = vq[i].a2v; bus_a.acc2_set_i = vq[i].a2s; bus_a.acc2_way_i = vq[i].a2w;
            bus_a.inv_v_i  = vq[i].iv;  bus_a.inv_set_i  = vq[i].is;  bus_a.inv_way_i  = vq[i].iw;
            bus_a.query_set_i = vq[i].qs; bus_a.lock_mask_i = vq[i].lock;
            tick();
            check($sformatf("vec%0d_valid", i), int'(bus_a.victim_valid_o), int'(vq[i].ev));
            check($sformatf("vec%0d_way", i),   int'(bus_a.victim_way_o),   int'(vq[i].ew));
        end

        // Reset asserted between edges must clear outputs before the next edge.
        idle_a();
        #3;
        reset_n_i = 1'b0;
        #1;
        check("midreset_valid", int'(bus_a.victim_valid_o), 0);
        check("midreset_way",   int'(bus_a.victim_way_o),   0);
        #1;
        reset_n_i = 1'b1;
        bus_a.query_set_i = 1'b1;
        tick();
        check("post_reset_set1_valid", int'(bus_a.victim_valid_o), 1);
        check("post_reset_set1_way",   int'(bus_a.victim_way_o),   0);
        bus_a.query_set_i = 1'b0;
        tick();
        check("post_reset_set0_way", int'(bus_a.victim_way_o), 0);

        // WAYS=8, SETS=3: set index 3 is out of range.
        drive_b(1,3,0, 0,0,0, 0,0,0, 3,8'h00);
        tick();
        check("b_q3_valid", int'(bus_b.victim_valid_o), 0);
        check("b_q3_way",   int'(bus_b.victim_way_o),   0);
        drive_b(1,2,0, 1,3,1, 0,0,0, 2,8'h00);
        tick();
        check("b_s2_valid", int'(bus_b.victim_valid_o), 1);
        check("b_s2_way",   int'(bus_b.victim_way_o),   1);
        drive_b(1,3,1, 0,0,0, 1,3,0, 2,8'h00);
        tick();
        check("b_s3_ignored", int'(bus_b.victim_way_o), 1);
        drive_b(1,0,7, 0,0,0, 0,0,0, 0,8'h00);
        tick();
        check("b_s0_w7", int'(bus_b.victim_way_o), 0);
        for (int w = 0; w < 7; w++) begin
            drive_b(1,0,w, 0,0,0, 0,0,0, 0,8'h00);
            tick();
        end
        check("b_s0_lru7", int'(bus_b.victim_way_o), 7);
        drive_b(0,0,0, 0,0,0, 0,0,0, 0,8'h80);
        tick();
        check("b_s0_lock7", int'(bus_b.victim_way_o), 0);
        drive_b(0,0,0, 0,0,0, 0,0,0, 0,8'hFF);
        tick();
        check("b_all_locked", int'(bus_b.victim_valid_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
